// File: rtl/lsu_stbuf_pkg.sv
// Shared store-buffer types: per-entry lifecycle state and the entry payload.
package lsu_stbuf_pkg;

  localparam int unsigned StbufDataW = 64;
  localparam int unsigned StbufBeW   = StbufDataW / 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StReady = 2'd2
  } stbuf_state_t;

  // The address lives in a separate array because its width is a module parameter.
  typedef struct packed {
    stbuf_state_t                state;
    logic [StbufDataW-1:0]       data;
    logic [StbufBeW-1:0]         byteen;
  } stbuf_entry_t;

endpackage

// File: rtl/lsu_stbuf_if.sv
// Store-buffer bus: dc3 allocate, dc5 commit/flush, DCCM drain and dc3 load forwarding.
interface lsu_stbuf_if #(
  parameter int unsigned ADDR_W = 32
) ();

  logic              store_stbuf_reqvld_dc3;
  logic [ADDR_W-1:0] stbuf_addr_dc3;
  logic [63:0]       stbuf_data_dc3;
  logic [7:0]        stbuf_byteen_dc3;
  logic              stbuf_commit_dc5;
  logic              stbuf_flush_dc5;
  logic              stbuf_reqvld_any;
  logic [ADDR_W-1:0] stbuf_addr_any;
  logic [63:0]       stbuf_data_any;
  logic [7:0]        stbuf_byteen_any;
  logic              stbuf_ack_any;
  logic              stbuf_reqvld_flushed_any;
  logic              lsu_stbuf_full_any;
  logic              lsu_stbuf_empty_any;
  logic [ADDR_W-1:0] load_addr_dc3;
  logic [7:0]        stbuf_fwdbyteen_dc3;
  logic [63:0]       stbuf_fwddata_dc3;

  modport slave (
    input  store_stbuf_reqvld_dc3, stbuf_addr_dc3, stbuf_data_dc3, stbuf_byteen_dc3,
    input  stbuf_commit_dc5, stbuf_flush_dc5, stbuf_ack_any, load_addr_dc3,
    output stbuf_reqvld_any, stbuf_addr_any, stbuf_data_any, stbuf_byteen_any,
    output stbuf_reqvld_flushed_any, lsu_stbuf_full_any, lsu_stbuf_empty_any,
    output stbuf_fwdbyteen_dc3, stbuf_fwddata_dc3
  );

  modport master (
    output store_stbuf_reqvld_dc3, stbuf_addr_dc3, stbuf_data_dc3, stbuf_byteen_dc3,
    output stbuf_commit_dc5, stbuf_flush_dc5, stbuf_ack_any, load_addr_dc3,
    input  stbuf_reqvld_any, stbuf_addr_any, stbuf_data_any, stbuf_byteen_any,
    input  stbuf_reqvld_flushed_any, lsu_stbuf_full_any, lsu_stbuf_empty_any,
    input  stbuf_fwdbyteen_dc3, stbuf_fwddata_dc3
  );

endinterface

// File: rtl/lsu_stbuf_fwd.sv
// Per-byte store-to-load forwarding: the youngest live entry matching the doubleword wins.
module lsu_stbuf_fwd
  import lsu_stbuf_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  localparam int unsigned PtrW  = $clog2(DEPTH),
  localparam int unsigned DwW   = ADDR_W - 3
) (
  input  stbuf_entry_t [DEPTH-1:0]          ent_i,
  input  logic         [DEPTH-1:0][DwW-1:0] addr_i,
  input  logic         [PtrW-1:0]           wr_ptr_i,
  input  logic         [DwW-1:0]            load_dw_i,
  output logic         [7:0]                fwdbyteen_o,
  output logic         [63:0]               fwddata_o
);

  logic [PtrW-1:0] idx;

  // Walk oldest to youngest starting at wr_ptr so later hits override earlier ones.
  always_comb begin
    fwdbyteen_o = '0;
    fwddata_o   = '0;
    idx         = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = wr_ptr_i + PtrW'(k);
      if (ent_i[idx].state != StIdle && addr_i[idx] == load_dw_i) begin
        for (int b = 0; b < 8; b++) begin
          if (ent_i[idx].byteen[b]) begin
            fwdbyteen_o[b]       = 1'b1;
            fwddata_o[8*b +: 8]  = ent_i[idx].data[8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/lsu_stbuf.sv
// LSU store buffer: dc3 allocate, dc5 commit/flush, in-order drain to DCCM.
// Define RV_STBUF_FWD_EN to enable store-to-load forwarding into dc3.
module lsu_stbuf
  import lsu_stbuf_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32
) (
  input logic         clk,
  input logic         rst,
  lsu_stbuf_if.slave  bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned DwW  = ADDR_W - 3;

  stbuf_entry_t [DEPTH-1:0]          ent_q, ent_d;
  logic         [DEPTH-1:0][DwW-1:0] addr_q, addr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, cmt_ptr_q, cmt_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d, killed;
  logic            flushed_q, flushed_d;

  logic full, reqvld, cmt_has_wait, ack_fire, commit_fire, alloc_ok;

  assign full         = (cnt_q == CntW'(DEPTH));
  assign reqvld       = (ent_q[rd_ptr_q].state == StReady);
  assign cmt_has_wait = (ent_q[cmt_ptr_q].state == StWait);
  assign ack_fire     = bus.stbuf_ack_any && reqvld;
  assign commit_fire  = bus.stbuf_commit_dc5 && cmt_has_wait;
  assign alloc_ok     = bus.store_stbuf_reqvld_dc3 && !full;

  // Same-cycle events are applied in age order: ack, commit, flush, allocate.
  always_comb begin
    ent_d     = ent_q;
    addr_d    = addr_q;
    wr_ptr_d  = wr_ptr_q;
    cmt_ptr_d = cmt_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    killed    = '0;
    flushed_d = 1'b0;

    if (ack_fire) begin
      ent_d[rd_ptr_q].state = StIdle;
      rd_ptr_d = rd_ptr_q + PtrW'(1);
      cnt_d    = cnt_d - CntW'(1);
    end

    if (commit_fire) begin
      ent_d[cmt_ptr_q].state = StReady;
      cmt_ptr_d = cmt_ptr_q + PtrW'(1);
    end

    if (bus.stbuf_flush_dc5) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (ent_d[i].state == StWait) begin
          ent_d[i].state = StIdle;
          killed = killed + CntW'(1);
        end
      end
      wr_ptr_d  = cmt_ptr_d;
      cnt_d     = cnt_d - killed;
      flushed_d = (killed != '0) || alloc_ok;
    end else if (alloc_ok) begin
      ent_d[wr_ptr_q] = '{state:  StWait,
                          data:   bus.stbuf_data_dc3,
                          byteen: bus.stbuf_byteen_dc3};
      addr_d[wr_ptr_q] = bus.stbuf_addr_dc3[ADDR_W-1:3];
      wr_ptr_d = wr_ptr_q + PtrW'(1);
      cnt_d    = cnt_d + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q     <= '0;
      addr_q    <= '0;
      wr_ptr_q  <= '0;
      cmt_ptr_q <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      flushed_q <= 1'b0;
    end else begin
      ent_q     <= ent_d;
      addr_q    <= addr_d;
      wr_ptr_q  <= wr_ptr_d;
      cmt_ptr_q <= cmt_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      flushed_q <= flushed_d;
    end
  end

  assign bus.stbuf_reqvld_any         = reqvld;
  assign bus.stbuf_addr_any           = reqvld ? {addr_q[rd_ptr_q], 3'b000} : '0;
  assign bus.stbuf_data_any           = reqvld ? ent_q[rd_ptr_q].data : '0;
  assign bus.stbuf_byteen_any         = reqvld ? ent_q[rd_ptr_q].byteen : '0;
  assign bus.stbuf_reqvld_flushed_any = flushed_q;
  assign bus.lsu_stbuf_full_any       = full;
  assign bus.lsu_stbuf_empty_any      = (cnt_q == '0);

  logic unused_store_lo;
  assign unused_store_lo = ^bus.stbuf_addr_dc3[2:0];

`ifdef RV_STBUF_FWD_EN
  logic [7:0]  fwdbyteen;
  logic [63:0] fwddata;
  logic        unused_load_lo;

  lsu_stbuf_fwd #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fwd (
    .ent_i       (ent_q),
    .addr_i      (addr_q),
    .wr_ptr_i    (wr_ptr_q),
    .load_dw_i   (bus.load_addr_dc3[ADDR_W-1:3]),
    .fwdbyteen_o (fwdbyteen),
    .fwddata_o   (fwddata)
  );

  assign bus.stbuf_fwdbyteen_dc3 = fwdbyteen;
  assign bus.stbuf_fwddata_dc3   = fwddata;
  assign unused_load_lo          = ^bus.load_addr_dc3[2:0];
`else
  logic unused_load;
  assign bus.stbuf_fwdbyteen_dc3 = '0;
  assign bus.stbuf_fwddata_dc3   = '0;
  assign unused_load             = ^bus.load_addr_dc3;
`endif

`ifndef SYNTHESIS
  a_no_alloc_when_full: assert property (@(posedge clk) disable iff (rst)
    !(bus.store_stbuf_reqvld_dc3 && full));
  a_commit_needs_wait: assert property (@(posedge clk) disable iff (rst)
    !(bus.stbuf_commit_dc5 && !cmt_has_wait));
`endif

endmodule

// File: tb/tb_lsu_stbuf.sv
// Store-buffer bench: directed scenarios plus random traffic against a queue reference model.
module tb_lsu_stbuf;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 32;
`ifdef RV_STBUF_FWD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_stbuf_if #(.ADDR_W(ADDR_W)) bus ();

  lsu_stbuf #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
    bit          cmt;
  } m_ent_t;

  m_ent_t mq[$];          // oldest at index 0
  bit     m_flushed;
  int     n_checks;
  int     n_fail;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_has_uncommitted();
    foreach (mq[i]) if (!mq[i].cmt) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_fwd(input logic [31:0] la, output logic [7:0] be, output logic [63:0] d);
    be = '0;
    d  = '0;
    for (int b = 0; b < 8; b++) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (FwdEn && mq[i].addr[31:3] == la[31:3] && mq[i].be[b]) begin
          be[b]      = 1'b1;
          d[8*b +: 8] = mq[i].data[8*b +: 8];
          break;
        end
      end
    end
  endtask

  task automatic check_outputs();
    bit          rv;
    logic [31:0] ea;
    logic [63:0] ed;
    logic [7:0]  eb;
    rv = (mq.size() > 0) && mq[0].cmt;
    ea = '0; ed = '0; eb = '0;
    if (rv) begin
      ea = mq[0].addr; ed = mq[0].data; eb = mq[0].be;
    end
    check_eq("reqvld", 64'(bus.stbuf_reqvld_any), 64'(rv));
    check_eq("drain_addr", 64'(bus.stbuf_addr_any), 64'(ea));
    check_eq("drain_data", bus.stbuf_data_any, ed);
    check_eq("drain_be", 64'(bus.stbuf_byteen_any), 64'(eb));
    check_eq("full", 64'(bus.lsu_stbuf_full_any), 64'(mq.size() == DEPTH));
    check_eq("empty", 64'(bus.lsu_stbuf_empty_any), 64'(mq.size() == 0));
    check_eq("flushed", 64'(bus.stbuf_reqvld_flushed_any), 64'(m_flushed));
  endtask

  task automatic do_cycle(input bit al, input logic [31:0] a, input logic [63:0] d,
                          input logic [7:0] be, input bit cm, input bit fl, input bit ak,
                          input logic [31:0] la);
    logic [7:0]  fbe;
    logic [63:0] fd;
    bit          was_full;
    int          killed;
    bus.store_stbuf_reqvld_dc3 = al;
    bus.stbuf_addr_dc3         = a;
    bus.stbuf_data_dc3         = d;
    bus.stbuf_byteen_dc3       = be;
    bus.stbuf_commit_dc5       = cm;
    bus.stbuf_flush_dc5        = fl;
    bus.stbuf_ack_any          = ak;
    bus.load_addr_dc3          = la;
    #1;
    model_fwd(la, fbe, fd);
    check_eq("fwd_be", 64'(bus.stbuf_fwdbyteen_dc3), 64'(fbe));
    check_eq("fwd_data", bus.stbuf_fwddata_dc3, fd);
    @(posedge clk);
    was_full = (mq.size() == DEPTH);
    killed   = 0;
    if (ak && mq.size() > 0 && mq[0].cmt) void'(mq.pop_front());
    if (cm) begin
      for (int i = 0; i < mq.size(); i++) begin
        if (!mq[i].cmt) begin
          mq[i].cmt = 1'b1;
          break;
        end
      end
    end
    if (fl) begin
      while (mq.size() > 0 && !mq[$].cmt) begin
        void'(mq.pop_back());
        killed++;
      end
    end
    if (al && !was_full) begin
      if (fl) killed++;
      else mq.push_back('{addr: {a[31:3], 3'b000}, data: d, be: be, cmt: 1'b0});
    end
    m_flushed = fl && (killed > 0);
    #1;
    check_outputs();
  endtask

  task automatic idle(input bit ak);
    do_cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, ak, '0);
  endtask

  task automatic alloc(input logic [31:0] a, input logic [63:0] d, input logic [7:0] be);
    do_cycle(1'b1, a, d, be, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    m_flushed = 1'b0;
    rst = 1'b1;
    bus.store_stbuf_reqvld_dc3 = 1'b0;
    bus.stbuf_addr_dc3   = '0;
    bus.stbuf_data_dc3   = '0;
    bus.stbuf_byteen_dc3 = '0;
    bus.stbuf_commit_dc5 = 1'b0;
    bus.stbuf_flush_dc5  = 1'b0;
    bus.stbuf_ack_any    = 1'b0;
    bus.load_addr_dc3    = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs();
    check_eq("rst_fwd_be", 64'(bus.stbuf_fwdbyteen_dc3), 64'h0);

    // Single store: alloc N, commit N+2, drain visible N+3, ack frees it.
    alloc(32'h100, 64'h1122334455667788, 8'hFF);
    idle(1'b0);
    do_cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0, '0);
    check_eq("single_reqvld", 64'(bus.stbuf_reqvld_any), 64'h1);
    check_eq("single_data", bus.stbuf_data_any, 64'h1122334455667788);
    idle(1'b1);
    check_eq("single_empty", 64'(bus.lsu_stbuf_empty_any), 64'h1);

    // Fill, then commit every cycle with ack held: back-to-back drains.
    for (int i = 0; i < 4; i++) alloc(32'h300 + 32'(8 * i), {2{32'(i + 1)}}, 8'hFF);
    check_eq("fill_full", 64'(bus.lsu_stbuf_full_any), 64'h1);
    for (int i = 0; i < 4; i++) do_cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1, '0);
    repeat (2) idle(1'b1);
    check_eq("fill_empty", 64'(bus.lsu_stbuf_empty_any), 64'h1);

    // Flush: 3 allocs, 1 commit, flush; next alloc reuses the killed slot.
    for (int i = 0; i < 3; i++) alloc(32'h400 + 32'(8 * i), {2{32'hA0 + 32'(i)}}, 8'h3C);
    do_cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0, '0);
    do_cycle(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0, '0);
    check_eq("flush_flag", 64'(bus.stbuf_reqvld_flushed_any), 64'h1);
    alloc(32'h500, 64'hDEADBEEF_CAFEF00D, 8'hF0);
    check_eq("flush_flag_1cyc", 64'(bus.stbuf_reqvld_flushed_any), 64'h0);
    do_cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1, '0);
    repeat (3) idle(1'b1);

    // Same-cycle commit + flush + allocate with two WAIT entries.
    alloc(32'h600, 64'h6666, 8'h01);
    alloc(32'h608, 64'h7777, 8'h02);
    do_cycle(1'b1, 32'h610, 64'h8888, 8'h04, 1'b1, 1'b1, 1'b0, '0);
    check_eq("cfa_flag", 64'(bus.stbuf_reqvld_flushed_any), 64'h1);
    check_eq("cfa_addr", 64'(bus.stbuf_addr_any), 64'h600);
    repeat (2) idle(1'b1);

    // Wrap the pointers several times with single-entry rounds.
    for (int r = 0; r < 10; r++) begin
      alloc(32'h700 + 32'(8 * r), {$urandom, $urandom}, 8'($urandom));
      idle(1'b1);
      do_cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1, '0);
      idle(1'b1);
    end

    // Forwarding: youngest match supplies each byte.
    alloc(32'h200, {8{8'hAA}}, 8'h0F);
    alloc(32'h204, {8{8'hBB}}, 8'h03);
    do_cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 32'h200);
    bus.load_addr_dc3 = 32'h200;
    #1;
    check_eq("fwd_dir_be", 64'(bus.stbuf_fwdbyteen_dc3), FwdEn ? 64'h0F : 64'h0);
    check_eq("fwd_dir_data", bus.stbuf_fwddata_dc3, FwdEn ? 64'hAAAA_BBBB : 64'h0);
    do_cycle(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0, '0);

    // Random legal traffic.
    for (int c = 0; c < 800; c++) begin
      bit          al, cm, fl, ak;
      logic [31:0] a, la;
      al = (mq.size() < DEPTH) && ($urandom_range(0, 99) < 55);
      cm = m_has_uncommitted() && ($urandom_range(0, 99) < 45);
      fl = ($urandom_range(0, 99) < 6);
      ak = ($urandom_range(0, 99) < 60);
      a  = 32'h200 + 32'($urandom_range(0, 3) * 8) + 32'($urandom_range(0, 7));
      la = 32'h200 + 32'($urandom_range(0, 3) * 8) + 32'($urandom_range(0, 7));
      do_cycle(al, a, {$urandom, $urandom}, 8'($urandom), cm, fl, ak, la);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
